// File: rtl/aes_encipher_iter.sv
// aes_encipher_iter: iterative AES-128/AES-256 block encipher.
//   SubBytes is spread over P = 16/SBOX_LANES cycles per round using
//   SBOX_LANES S-box instances, so one round costs P+1 cycles.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   next, keylen, block  start request, key size (1 = AES-256), plaintext
//   round, round_key     round-key index out, matching key in (same cycle)
//   new_block            ciphertext, held until the next completion
//   ready, done          idle flag, one-cycle completion pulse (both registered)

// Single S-box lane: multiplicative inverse in GF(2^8) followed by the
// affine transform. Inverse is a^254, built from repeated squaring.
module aes_encipher_iter_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] m);
    logic [7:0] p, v;
    p = '0;
    v = x;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) p = p ^ v;
      v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] p2, p4, p8, p16, p32, p64, p128, inv;

  assign p2   = gmul(a, a);
  assign p4   = gmul(p2, p2);
  assign p8   = gmul(p4, p4);
  assign p16  = gmul(p8, p8);
  assign p32  = gmul(p16, p16);
  assign p64  = gmul(p32, p32);
  assign p128 = gmul(p64, p64);
  // 2+4+...+128 = 254; zero maps to zero as required
  assign inv  = gmul(gmul(gmul(p2, p4), gmul(p8, p16)), gmul(gmul(p32, p64), p128));
  assign y    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_encipher_iter #(
  parameter int SBOX_LANES = 16,
  parameter bit KEY256_EN  = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         next,
  input  logic         keylen,
  input  logic [127:0] block,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic [127:0] new_block,
  output logic         ready,
  output logic         done
);
  localparam int P  = 16 / SBOX_LANES;
  localparam int CW = (P > 1) ? $clog2(P) : 1;

  generate
    if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4 ||
          SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
      $error("SBOX_LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, INIT, SUB, ROUND} fsm_t;

  fsm_t          fsm, fsm_nxt;
  logic [127:0]  state, state_nxt, nb_nxt;
  logic [3:0]    rnd_ctr, rnd_nxt;
  logic [CW-1:0] chk, chk_nxt;
  logic          len, len_nxt, done_nxt, last;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // byte k lives at [127-8k -: 8]; row r of column c is byte r+4c
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  // State viewed as P chunks of SBOX_LANES bytes; chunk 0 is the MSB end,
  // which is the highest index of the packed chunk dimension.
  logic [P-1:0][SBOX_LANES-1:0][7:0] st_chunks, sub_chunks;
  logic [SBOX_LANES-1:0][7:0]        sb_in, sb_out;
  logic [CW-1:0]                     chunk_sel;

  assign st_chunks = state;
  assign chunk_sel = CW'(P-1) - chk;
  assign sb_in     = st_chunks[chunk_sel];

  for (genvar g = 0; g < SBOX_LANES; g++) begin : g_lane
    aes_encipher_iter_sbox u_sbox (.a(sb_in[g]), .y(sb_out[g]));
  end

  always_comb begin
    sub_chunks            = st_chunks;
    sub_chunks[chunk_sel] = sb_out;
  end

  assign last = (rnd_ctr == (len ? 4'd14 : 4'd10));

  always_comb begin
    fsm_nxt   = fsm;
    state_nxt = state;
    rnd_nxt   = rnd_ctr;
    chk_nxt   = chk;
    len_nxt   = len;
    nb_nxt    = new_block;
    done_nxt  = 1'b0;
    round     = 4'd0;
    case (fsm)
      IDLE: begin
        if (next) begin
          state_nxt = block;
          len_nxt   = KEY256_EN ? keylen : 1'b0;
          fsm_nxt   = INIT;
        end
      end
      INIT: begin
        state_nxt = state ^ round_key;
        rnd_nxt   = 4'd1;
        chk_nxt   = '0;
        fsm_nxt   = SUB;
      end
      SUB: begin
        // round_key for this round is requested early but not used here
        round     = rnd_ctr;
        state_nxt = sub_chunks;
        chk_nxt   = chk + 1'b1;
        if (chk == CW'(P-1)) fsm_nxt = ROUND;
      end
      ROUND: begin
        round = rnd_ctr;
        if (last) begin
          nb_nxt   = shift_rows(state) ^ round_key;
          done_nxt = 1'b1;
          fsm_nxt  = IDLE;
        end else begin
          state_nxt = mix_cols(shift_rows(state)) ^ round_key;
          rnd_nxt   = rnd_ctr + 4'd1;
          chk_nxt   = '0;
          fsm_nxt   = SUB;
        end
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      state     <= '0;
      rnd_ctr   <= '0;
      len       <= 1'b0;
      new_block <= '0;
      ready     <= 1'b1;
      done      <= 1'b0;
    end else begin
      fsm       <= fsm_nxt;
      state     <= state_nxt;
      rnd_ctr   <= rnd_nxt;
      len       <= len_nxt;
      new_block <= nb_nxt;
      ready     <= (fsm_nxt == IDLE);
      done      <= done_nxt;
    end
  end

  // with a single chunk per round there is nothing to count
  generate
    if (P > 1) begin : g_chk
      always_ff @(posedge clk) begin
        if (!rst_n) chk <= '0;
        else        chk <= chk_nxt;
      end
    end else begin : g_no_chk
      logic chk_unused;
      assign chk        = '0;
      assign chk_unused = ^chk_nxt;
    end
  endgenerate
endmodule
